mmu_loader: RTL
===============

# mmu_loader

Upstream stage of the MMU feeder. It accepts a 2x2 weight matrix and a 2x2 input matrix from the host as a serial byte stream into a shadow bank. Once all 8 bytes are loaded, it commits them to an active bank that drives the feeder's weight/input ports. It then sequences `en` and `mmu_cycle` through one complete multiply (cycles 0..5), and inserts a one-cycle clear gap between back-to-back multiplies.

## Interface
Parameters:
- `LAST_CYCLE`, default 5: final `mmu_cycle` value of a run.
- `DW`, default 8: operand byte width.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `load_valid`  in  1: host byte valid.
- `load_data`  in  DW: host byte.
- `load_ready`  out  1: shadow bank can accept a byte.
- `weight0..weight3`  out  DW each: active weights, row-major.
- `input0..input3`  out  DW each: active inputs, row-major.
- `en`  out  1: feeder enable.
- `mmu_cycle`  out  3: feeder cycle index.
- `busy`  out  1: a run is in progress or a matrix is pending.

## Operation
- **Byte transfer.** A byte is accepted when `load_valid && load_ready`.
- **Write pointer.** `wr_ptr` (3 bits) advances on each accepted byte.
  - Byte k in 0..3 goes to shadow weight[k].
  - Byte k in 4..7 goes to shadow input[k-4].
- **Pending flag.**
  - On accepting byte 7, `wr_ptr` wraps to 0 and `pending` is set.
  - `load_ready = !pending`.
  - Loading is allowed during RUN/FLUSH, which makes the banks double-buffered.
- **FSM states:** IDLE, RUN, FLUSH.
  - IDLE: `en`=0, `mmu_cycle`=0. If `pending`: commit and go to RUN.
  - RUN: `en`=1, `mmu_cycle` increments by 1 per clock starting at 0. At `LAST_CYCLE`, go to FLUSH.
  - FLUSH: `en`=0, `mmu_cycle`=0 for exactly one cycle, which lets the feeder assert clear. Then, if `pending`: commit and go to RUN; else go to IDLE.
- **Commit** happens on the same edge that enters RUN:
  - active bank <= shadow bank;
  - `pending` <= 0.
  - The active bank is therefore stable for the whole run, including the `mmu_cycle`=0 sample.
- **Active bank** changes only on commit.
- **Busy:** `busy = (state != IDLE) || pending`.
- **Reset** is asynchronous and may be asserted mid-operation. It clears:
  - state to IDLE and `wr_ptr` to 0;
  - `pending` to 0;
  - both banks to 0.
  - A partially loaded shadow is discarded.
- **Reset values of outputs:**
  - `load_ready`=1;
  - weight*/input* = 0;
  - `en`=0, `mmu_cycle`=0, `busy`=0.

## Timing
- Byte 7 accepted on edge t: `pending`=1 and `load_ready`=0 from t. Commit happens on edge t+1, so RUN with `mmu_cycle`=0 and `en`=1 is visible from t+1.
- A run lasts `LAST_CYCLE`+1 = 6 cycles of `en`=1, followed by 1 FLUSH cycle.
- Back-to-back throughput: one matrix every 7 cycles, provided the next 8 bytes arrive within the current run.
- Because `load_ready` is 0 while `pending`, no byte can be accepted in a commit cycle. `load_ready` returns to 1 on the edge after commit.
- If `load_valid` is held with `load_ready`=0, the byte is not consumed and `wr_ptr` is unchanged.
- All outputs are registered except `load_ready` and `busy`, which are decoded combinationally from registers.

## Structure
- **Shared package/include** holds:
  - state encoding (IDLE=0, RUN=1, FLUSH=2);
  - `LOAD_BYTES`=8;
  - `MMU_LAST_CYCLE`=5, which is also used by the feeder's `done` window.
- **Sub-module `operand_bank`:** 8 x DW register file with:
  - byte-indexed write port;
  - bulk copy-in;
  - flat 8-byte output.
  - It is instantiated twice (shadow and active).
- The FSM, `wr_ptr` and `pending` live in the top module.

## Test plan
- **Basic load:** reset, then bytes 1..8 with `load_valid` held 1.
  - `load_ready` drops after byte 8.
  - One cycle later: weights = 1,2,3,4 and inputs = 5,6,7,8; `en`=1 with `mmu_cycle` 0,1,2,3,4,5; then `en`=0 for one cycle; then IDLE with `busy`=0.
- **Back-to-back:** load A (1..8), then load B (9..16) while A runs.
  - B commits on the edge leaving FLUSH.
  - Exactly one `en`=0 cycle separates the runs, and weight0 changes 1->9 only at B's `mmu_cycle`=0.
- **Backpressure:** with B pending and A running, drive byte 0xAA.
  - `load_ready`=0, so the byte is not accepted and the shadow is unchanged.
  - The byte is accepted on the cycle after B commits.
- **Gapped valid:** bytes with random `load_valid` gaps.
  - Byte ordering is preserved; commit occurs only after the 8th accepted byte.
- **Mid-load reset:** 5 bytes loaded, then `rst` pulse, then full load of 0x10..0x17.
  - Active bank = 0x10..0x17, with no stale bytes.
- **Mid-run reset:** `rst` at `mmu_cycle`=3.
  - `en`, `mmu_cycle`, weights and `busy` immediately 0; `load_ready`=1.

Source files
------------

// File: rtl/mmu_loader_pkg.sv
// Shared constants and state encoding for the MMU loader and its feeder.
package mmu_loader_pkg;

    localparam int unsigned LOAD_BYTES     = 8;
    localparam int unsigned PTR_W          = $clog2(LOAD_BYTES);
    localparam int unsigned CYC_W          = 3;
    localparam int unsigned MMU_LAST_CYCLE = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

endpackage

// File: rtl/mmu_loader_if.sv
// Host byte-load channel plus the operand/sequencing outputs toward the feeder.
interface mmu_loader_if
    import mmu_loader_pkg::*;
#(
    parameter int unsigned DW = 8
);
    logic             load_valid;
    logic [DW-1:0]    load_data;
    logic             load_ready;
    logic [DW-1:0]    weight0, weight1, weight2, weight3;
    logic [DW-1:0]    input0, input1, input2, input3;
    logic             en;
    logic [CYC_W-1:0] mmu_cycle;
    logic             busy;

    modport master (
        output load_valid, load_data,
        input  load_ready, weight0, weight1, weight2, weight3,
               input0, input1, input2, input3, en, mmu_cycle, busy
    );

    modport slave (
        input  load_valid, load_data,
        output load_ready, weight0, weight1, weight2, weight3,
               input0, input1, input2, input3, en, mmu_cycle, busy
    );
endinterface

// File: rtl/mmu_loader_operand_bank.sv
// Eight-byte operand register file: byte-indexed write, bulk copy-in, flat read-out.
module operand_bank
    import mmu_loader_pkg::*;
#(
    parameter int unsigned DW = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [PTR_W-1:0]         wr_idx,
    input  logic [DW-1:0]            wr_data,
    input  logic                     copy_en,
    input  logic [LOAD_BYTES*DW-1:0] copy_data,
    output logic [LOAD_BYTES*DW-1:0] data
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data <= '0;
        end else if (copy_en) begin
            data <= copy_data;
        end else if (wr_en) begin
            data[int'(wr_idx)*DW +: DW] <= wr_data;
        end
    end
endmodule

// File: rtl/mmu_loader.sv
// Loads a 2x2 weight and 2x2 input matrix byte-serially into a shadow bank,
// commits it to the active bank and sequences one feeder run per matrix.
module mmu_loader
    import mmu_loader_pkg::*;
#(
    parameter int unsigned LAST_CYCLE = MMU_LAST_CYCLE,
    parameter int unsigned DW         = 8
) (
    input logic         clk,
    input logic         rst,
    mmu_loader_if.slave bus
);
    state_t                   state, state_n;
    logic [CYC_W-1:0]         cyc, cyc_n;
    logic                     en_q, en_n;
    logic                     commit;
    logic                     pending;
    logic                     accept;
    logic [PTR_W-1:0]         wr_ptr;
    logic [LOAD_BYTES*DW-1:0] shadow_q, active_q;

    assign accept = bus.load_valid && !pending;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cyc   <= '0;
            en_q  <= 1'b0;
        end else begin
            state <= state_n;
            cyc   <= cyc_n;
            en_q  <= en_n;
        end
    end

    always_comb begin
        state_n = state;
        cyc_n   = '0;
        commit  = 1'b0;
        unique case (state)
            IDLE: begin
                if (pending) begin
                    commit  = 1'b1;
                    state_n = RUN;
                end
            end
            RUN: begin
                if (cyc == CYC_W'(LAST_CYCLE)) begin
                    state_n = FLUSH;
                end else begin
                    cyc_n = cyc + CYC_W'(1);
                end
            end
            FLUSH: begin
                if (pending) begin
                    commit  = 1'b1;
                    state_n = RUN;
                end else begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        en_n = (state_n == RUN);
    end

    // accept and commit are mutually exclusive: accept needs !pending, commit needs pending
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            pending <= 1'b0;
        end else if (accept) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
            if (wr_ptr == PTR_W'(LOAD_BYTES - 1)) begin
                pending <= 1'b1;
            end
        end else if (commit) begin
            pending <= 1'b0;
        end
    end

    operand_bank #(.DW(DW)) u_shadow (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (accept),
        .wr_idx    (wr_ptr),
        .wr_data   (bus.load_data),
        .copy_en   (1'b0),
        .copy_data ('0),
        .data      (shadow_q)
    );

    operand_bank #(.DW(DW)) u_active (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (1'b0),
        .wr_idx    ('0),
        .wr_data   ('0),
        .copy_en   (commit),
        .copy_data (shadow_q),
        .data      (active_q)
    );

    assign bus.load_ready = !pending;
    assign bus.busy       = (state != IDLE) || pending;
    assign bus.en         = en_q;
    assign bus.mmu_cycle  = cyc;
    assign bus.weight0    = active_q[0*DW +: DW];
    assign bus.weight1    = active_q[1*DW +: DW];
    assign bus.weight2    = active_q[2*DW +: DW];
    assign bus.weight3    = active_q[3*DW +: DW];
    assign bus.input0     = active_q[4*DW +: DW];
    assign bus.input1     = active_q[5*DW +: DW];
    assign bus.input2     = active_q[6*DW +: DW];
    assign bus.input3     = active_q[7*DW +: DW];
endmodule
